// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce engine: a prescaler paces scan ticks, a
// round-robin pointer picks one channel per tick, and that channel's
// agreement counter decides when a new level is accepted. Each accepted
// edge produces a registered one-cycle event carrying channel and direction.
module debounce_scan_ctrl #(
  parameter int N_CH   = 8,
  parameter int DIV    = 4,
  parameter int THRESH = 4,
  parameter int CNT_W  = 4,
  parameter int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_CH-1:0]  raw_in,
  output logic [N_CH-1:0]  stable_out,
  output logic             evt_valid,
  output logic [PTR_W-1:0] evt_ch,
  output logic             evt_rise,
  output logic [PTR_W-1:0] scan_ch
);

  localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(THRESH - 1);

  logic [N_CH-1:0]   sync_p0;
  logic [N_CH-1:0]   sync_p1;
  logic [PCNT_W-1:0] pcnt;
  logic [PTR_W-1:0]  ch_ptr;
  logic [N_CH-1:0]   stable_q;
  logic [CNT_W-1:0]  cnt [N_CH];

  logic             tick;
  logic             cur_s;
  logic             cur_stable;
  logic [CNT_W-1:0] cur_cnt;
  logic             accept;

  // Stage p0 -> p1: two-flop synchronizer, free-running regardless of ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Prescaler and round-robin pointer; both freeze while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt   <= '0;
      ch_ptr <= '0;
    end else if (ena) begin
      if (pcnt == PCNT_LAST) begin
        pcnt   <= '0;
        ch_ptr <= (ch_ptr == PTR_LAST) ? '0 : ch_ptr + PTR_W'(1);
      end else begin
        pcnt <= pcnt + PCNT_W'(1);
      end
    end
  end

  // Look up the addressed channel and decide whether this tick accepts an edge
  always_comb begin
    tick       = ena && (pcnt == PCNT_LAST);
    cur_s      = sync_p1[ch_ptr];
    cur_stable = stable_q[ch_ptr];
    cur_cnt    = cnt[ch_ptr];
    accept     = tick && (cur_s != cur_stable) && (cur_cnt == CNT_LAST);
  end

  // Per-channel counters and stable levels; only the addressed channel moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_ptr == PTR_W'(i)) begin
          if (sync_p1[i] == stable_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable_q[i] <= sync_p1[i];
            cnt[i]      <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Registered event; channel and direction hold between events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
    end else begin
      evt_valid <= accept;
      if (accept) begin
        evt_ch   <= ch_ptr;
        evt_rise <= cur_s;
      end
    end
  end

  assign stable_out = stable_q;
  assign scan_ch    = ch_ptr;

endmodule
